// File: rtl/encoder_pkg.sv
// Shared definitions for the encoder_4 slice.
//   ENC_IN_W / ENC_OUT_W : only supported request and index widths
//   enc_idx_t            : encoded index type
//   popcount_ge2()       : 1 when two or more request bits are set
package encoder_pkg;

    localparam int unsigned ENC_IN_W  = 4;
    localparam int unsigned ENC_OUT_W = 2;

    typedef logic [ENC_OUT_W-1:0] enc_idx_t;

    function automatic logic popcount_ge2(input logic [ENC_IN_W-1:0] v);
        int unsigned cnt;
        cnt = 0;
        for (int i = 0; i < int'(ENC_IN_W); i++) begin
            cnt += 32'(v[i]);
        end
        return (cnt >= 2);
    endfunction

endpackage

// File: rtl/encoder_4_core.sv
// Combinational 4-to-2 priority mux.
// Parameters:
//   LSB_PRIO : 0 = highest set bit wins, 1 = lowest set bit wins
// Ports:
//   in    : request vector, bit i requests index i
//   idx   : index of the winning bit (0 when nothing is requested)
//   any   : at least one request bit set
//   multi : two or more request bits set
module encoder_4_core
    import encoder_pkg::*;
#(
    parameter int unsigned LSB_PRIO = 0
) (
    input  logic [ENC_IN_W-1:0]  in,
    output logic [ENC_OUT_W-1:0] idx,
    output logic                 any,
    output logic                 multi
);

    always_comb begin
        idx   = '0;
        any   = |in;
        multi = popcount_ge2(in);
        if (LSB_PRIO != 0) begin
            if (in[0])      idx = 2'd0;
            else if (in[1]) idx = 2'd1;
            else if (in[2]) idx = 2'd2;
            else if (in[3]) idx = 2'd3;
            else            idx = 2'd0;
        end else begin
            if (in[3])      idx = 2'd3;
            else if (in[2]) idx = 2'd2;
            else if (in[1]) idx = 2'd1;
            else if (in[0]) idx = 2'd0;
            else            idx = 2'd0;
        end
    end

endmodule

// File: rtl/encoder_4.sv
// Registered 4-to-2 priority encoder with valid/multi flags, one cycle latency.
// Parameters:
//   IN_W     : request width, must be 4
//   OUT_W    : index width, must be 2
//   LSB_PRIO : 0 = highest set bit wins, 1 = lowest set bit wins
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   in    : request vector
//   out   : registered winning index
//   valid : registered, sampled in had any bit set
//   multi : registered, sampled in had two or more bits set
//   err   : registered, sampled in was not exactly one-hot
//           (only when ENCODER_4_ONEHOT_CHK_EN is defined)
// Build option: `define ENCODER_4_ONEHOT_CHK_EN adds err and a sticky err_seen flag.
module encoder_4
    import encoder_pkg::*;
#(
    parameter int unsigned IN_W     = 4,
    parameter int unsigned OUT_W    = 2,
    parameter int unsigned LSB_PRIO = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IN_W-1:0]  in,
    output logic [OUT_W-1:0] out,
    output logic             valid,
    output logic             multi
`ifdef ENCODER_4_ONEHOT_CHK_EN
    ,
    output logic             err
`endif
);

    if (IN_W != ENC_IN_W || OUT_W != ENC_OUT_W) begin : g_bad_width
        $error("encoder_4: only IN_W=4, OUT_W=2 is supported");
    end
    if (LSB_PRIO > 1) begin : g_bad_prio
        $error("encoder_4: LSB_PRIO must be 0 or 1");
    end

    enc_idx_t idx_c;
    logic     any_c;
    logic     multi_c;

    encoder_4_core #(
        .LSB_PRIO (LSB_PRIO)
    ) u_core (
        .in    (in),
        .idx   (idx_c),
        .any   (any_c),
        .multi (multi_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out   <= '0;
            valid <= 1'b0;
            multi <= 1'b0;
        end else begin
            out   <= idx_c;
            valid <= any_c;
            multi <= multi_c;
        end
    end

`ifdef ENCODER_4_ONEHOT_CHK_EN
    // Not one-hot means either nothing set or more than one bit set.
    logic err_c;
    logic err_seen;

    assign err_c = !any_c || multi_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err      <= 1'b0;
            err_seen <= 1'b0;
        end else begin
            err      <= err_c;
            err_seen <= err_seen | err_c;
        end
    end

    // err_seen is updated on the same edge as err, so it can never lag behind.
    always @(posedge clk) begin
        if (rst_n && err) begin
            assert (err_seen) else $error("encoder_4: err set without err_seen");
        end
    end
`endif

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (rst_n) begin
            assert (!$isunknown(in)) else $error("encoder_4: X/Z on in");
        end
    end
`endif

endmodule

// File: tb/tb_encoder_4.sv
module tb_encoder_4;

    logic       clk;
    logic       rst_n;
    logic [3:0] in;

    logic [1:0] out_m, out_l;
    logic       valid_m, valid_l, multi_m, multi_l;
    logic [4:0] obs_m, obs_l;
    logic [4:0] exp_m, exp_l;

    int total = 0;
    int bad   = 0;

`ifdef ENCODER_4_ONEHOT_CHK_EN
    logic err_m, err_l;
    assign obs_m = {err_m, out_m, valid_m, multi_m};
    assign obs_l = {err_l, out_l, valid_l, multi_l};
`else
    assign obs_m = {1'b0, out_m, valid_m, multi_m};
    assign obs_l = {1'b0, out_l, valid_l, multi_l};
`endif

    encoder_4 #(.IN_W(4), .OUT_W(2), .LSB_PRIO(0)) dut_m (
        .clk   (clk),
        .rst_n (rst_n),
        .in    (in),
        .out   (out_m),
        .valid (valid_m),
        .multi (multi_m)
`ifdef ENCODER_4_ONEHOT_CHK_EN
        ,
        .err   (err_m)
`endif
    );

    encoder_4 #(.IN_W(4), .OUT_W(2), .LSB_PRIO(1)) dut_l (
        .clk   (clk),
        .rst_n (rst_n),
        .in    (in),
        .out   (out_l),
        .valid (valid_l),
        .multi (multi_l)
`ifdef ENCODER_4_ONEHOT_CHK_EN
        ,
        .err   (err_l)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: count set bits, pick the first or last one found while scanning upward.
    // Result packing is {err, out[1:0], valid, multi}.
    function automatic logic [4:0] model(input logic [3:0] v, input bit lsb_first);
        int n;
        int win;
        logic e;
        n   = 0;
        win = 0;
        for (int i = 0; i < 4; i++) begin
            if (v[i]) begin
                n++;
                if (!lsb_first || n == 1) win = i;
            end
        end
`ifdef ENCODER_4_ONEHOT_CHK_EN
        e = (n != 1);
`else
        e = 1'b0;
`endif
        return {e, 2'(win), (n > 0), (n >= 2)};
    endfunction

    task automatic check(input string tag, input logic [3:0] stim,
                         input logic [4:0] got, input logic [4:0] want);
        total++;
        assert (got === want) else begin
            bad++;
            $error("FAIL %s in=%b observed{err,out,valid,multi}=%b expected=%b",
                   tag, stim, got, want);
        end
    endtask

    // New vector at the negedge; outputs must hold until the next rising edge,
    // then show that vector's encoding.
    task automatic apply(input string tag, input logic [3:0] v);
        @(negedge clk);
        in = v;
        #1;
        check({tag, "_hold_m"}, v, obs_m, exp_m);
        check({tag, "_hold_l"}, v, obs_l, exp_l);
        @(posedge clk);
        #1;
        exp_m = model(v, 1'b0);
        exp_l = model(v, 1'b1);
        check({tag, "_m"}, v, obs_m, exp_m);
        check({tag, "_l"}, v, obs_l, exp_l);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] v;
        int unsigned k;
        int unsigned off;

        // Held in reset with a request present: outputs stay cleared.
        rst_n = 1'b0;
        in    = 4'b1000;
        exp_m = '0;
        exp_l = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_hold_m", in, obs_m, exp_m);
        check("rst_hold_l", in, obs_l, exp_l);

        // First capture happens on the first edge after release.
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_rel_pre_m", in, obs_m, exp_m);
        @(posedge clk);
        #1;
        exp_m = model(in, 1'b0);
        exp_l = model(in, 1'b1);
        check("rst_rel_m", in, obs_m, exp_m);
        check("rst_rel_l", in, obs_l, exp_l);
        check("rst_rel_m_lit", in, obs_m, {1'b0, 2'd3, 1'b1, 1'b0});

        // Walking one.
        for (int i = 0; i < 4; i++) begin
            apply("walk", 4'(1 << i));
            check("walk_lit", in, {1'b0, obs_m[3:0]}, {1'b0, 2'(i), 1'b1, 1'b0});
        end

        apply("zero", 4'b0000);
        apply("multi", 4'b0011);
        check("multi_0011_lit", in, {1'b0, obs_m[3:0]}, {1'b0, 2'd1, 1'b1, 1'b1});
        apply("multi", 4'b1001);
        check("multi_1001_lit", in, {1'b0, obs_m[3:0]}, {1'b0, 2'd3, 1'b1, 1'b1});
        apply("multi", 4'b1111);
        check("multi_1111_lit", in, {1'b0, obs_m[3:0]}, {1'b0, 2'd3, 1'b1, 1'b1});

        apply("lsb", 4'b1100);
        check("lsb_1100_lit", in, {1'b0, obs_l[3:0]}, {1'b0, 2'd2, 1'b1, 1'b1});
        apply("lsb", 4'b1001);
        check("lsb_1001_lit", in, {1'b0, obs_l[3:0]}, {1'b0, 2'd0, 1'b1, 1'b1});
        apply("lsb", 4'b1000);
        check("lsb_1000_lit", in, {1'b0, obs_l[3:0]}, {1'b0, 2'd3, 1'b1, 1'b0});

        // Mid-cycle reset clears outputs without a clock edge.
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        exp_m = '0;
        exp_l = '0;
        check("rst_async_m", in, obs_m, exp_m);
        check("rst_async_l", in, obs_l, exp_l);
        @(posedge clk);
        #1;
        check("rst_async_edge_m", in, obs_m, exp_m);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        exp_m = model(in, 1'b0);
        exp_l = model(in, 1'b1);
        check("rst_async_rel_m", in, obs_m, exp_m);
        check("rst_async_rel_l", in, obs_l, exp_l);

        // Back-to-back stream covering all 16 values (odd stride permutes mod 16).
        k   = ($urandom % 8) * 2 + 1;
        off = $urandom % 16;
        for (int i = 0; i < 16; i++) begin
            v = 4'(32'(i) * k + off);
            apply("stream", v);
        end

        // Random vectors.
        for (int i = 0; i < 40; i++) begin
            v = 4'($urandom);
            apply("rand", v);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/encoder_4.md
Name: encoder_4

Overview:
- Registered 4-to-2 priority encoder with a valid flag.
- Converts a 4-bit request vector into the 2-bit index of its highest set bit.
- Used as a general-purpose select/arbitration helper in the risc32i datapath, e.g. one-hot to index conversion for register and mux selects.
- Output is registered: one clock of latency.

Parameters:
- IN_W, 4, input vector width; only 4 is supported, and any other value is an elaboration error.
- OUT_W, 2, index width; must equal clog2(IN_W).
- LSB_PRIO, 0, priority direction: 0 = highest set bit wins, 1 = lowest set bit wins.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in  input  IN_W  request vector; bit i asserted means index i is requested.
- out  output  OUT_W  registered encoded index of the winning bit.
- valid  output  1  registered; 1 when the sampled `in` had at least one bit set.
- multi  output  1  registered; 1 when the sampled `in` had two or more bits set.
- err  output  1  present only with ENCODER_4_ONEHOT_CHK_EN; see Optional Feature.

Behaviour:
- Reset: rst_n low clears out=0, valid=0, multi=0 (and err=0) immediately, independent of clk. Release is synchronous to the next rising edge; the first capture happens on the first rising edge with rst_n high.
- Each rising edge with rst_n high captures `in` and registers the encoding. Latency is exactly 1 cycle and throughput is 1 vector per cycle; there is no handshake.
- Encoding with LSB_PRIO=0:
  - in[3]=1 gives out=3.
  - Otherwise in[2]=1 gives out=2.
  - Otherwise in[1]=1 gives out=1.
  - Otherwise in[0]=1 gives out=0.
- With LSB_PRIO=1 the same scan runs from bit 0 upward.
- in=0000: out=0, valid=0, multi=0. out=0 with valid=0 is distinct from in=0001, which gives out=0 with valid=1.
- Multi-hot input: the winner follows the priority rule above and multi=1. Examples with LSB_PRIO=0: 0011 gives out=1, 1001 gives out=3, 1111 gives out=3.
- Only `in` is sampled, and outputs hold their value until the next edge.
- X/Z on `in` is not handled. It must be reported by a simulation-only assertion (non-synthesizable) when rst_n is high.
- Combinational core: a pure priority mux. It contains no latches, and all branches assign every output.

Optional Feature:
- Macro: ENCODER_4_ONEHOT_CHK_EN.
- Defined:
  - Adds output `err`, registered with 1-cycle latency.
  - err=1 when the sampled `in` was not exactly one-hot (zero or multi-hot).
  - Also adds a sticky `err_seen` internal flag, cleared only by rst_n, exposed for assertions.
- Undefined:
  - The `err` port and its logic are absent.
  - All other outputs behave identically.

Decomposition:
- Shared package encoder_pkg holds:
  - localparams ENC_IN_W=4 and ENC_OUT_W=2;
  - a typedef for the index type, logic [ENC_OUT_W-1:0];
  - a function popcount_ge2 used for `multi`.
- One sub-module: encoder_4_core, combinational.
  - Inputs: in, LSB_PRIO.
  - Outputs: idx, any, multi.
- encoder_4 wraps encoder_4_core with the output registers, the reset logic and the optional checker.

Test Plan:
- Reset: assert rst_n=0 mid-cycle with in=1000 -> out=0, valid=0, multi=0 immediately (no clk edge needed); release -> next edge out=3, valid=1.
- Walking one, LSB_PRIO=0: in=0001,0010,0100,1000 on successive edges -> out=0,1,2,3 one cycle later, valid=1, multi=0.
- Zero input: in=0000 -> out=0, valid=0, multi=0; under the macro, err=1.
- Multi-hot, LSB_PRIO=0: in=0011 -> out=1; in=1001 -> out=3; in=1111 -> out=3. All with valid=1 and multi=1; under the macro, err=1.
- LSB_PRIO=1 instance: in=1100 -> out=2; in=1001 -> out=0; in=1000 -> out=3, multi=0.
- Back-to-back stream: a new vector every cycle for 16 cycles covering all 16 values. Compare against a reference model with 1-cycle delay and require no bubbles.
